// File: rtl/elevator_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_scheduler
//
// Single-car elevator controller. Floor calls are latched every clock. The car
// FSM only advances on the `tick` strobe: it moves one floor per MOVE_TICKS
// ticks and holds the door open for DOOR_TICKS ticks. Scheduling keeps going
// in the current direction while there are calls ahead, and reverses only when
// nothing is left that way.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   tick           single-cycle advance strobe; all timing moves only on it
//   estop          (only with ELEV_ESTOP_EN) freeze car, counters and floor
//   call_req       per-floor call pulses, sampled every clk
//   pending        latched outstanding calls
//   current_floor  floor the car is at, or last departed
//   sim_state      00 idle, 01 moving up, 10 moving down, 11 door open
//   destination    one-hot target floor (display use)
//   arrive         one-clk pulse when the door opens
//
// Optional feature
//   ELEV_ESTOP_EN  define to add the `estop` input. While estop is high the
//                  car is frozen and sim_state reads 00; calls still latch.
// -----------------------------------------------------------------------------
module elevator_scheduler #(
  parameter int NUM_FLOORS = 8,
  parameter int MOVE_TICKS = 16,
  parameter int DOOR_TICKS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
`ifdef ELEV_ESTOP_EN
  input  logic                          estop,
`endif
  input  logic [NUM_FLOORS-1:0]         call_req,
  output logic [NUM_FLOORS-1:0]         pending,
  output logic [$clog2(NUM_FLOORS)-1:0] current_floor,
  output logic [1:0]                    sim_state,
  output logic [NUM_FLOORS-1:0]         destination,
  output logic                          arrive
);

  localparam int FW = $clog2(NUM_FLOORS);
  localparam int MW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

  localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_TICKS - 1);

  // Encodings double as the sim_state display code.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10,
    ST_DOOR = 2'b11
  } state_t;

  state_t        state, state_next;
  logic          dir, dir_next;           // 1 = up
  logic [FW-1:0] floor_next;
  logic [MW-1:0] move_cnt, move_next;
  logic [DW-1:0] door_cnt, door_next;
  logic [NUM_FLOORS-1:0] pending_next;
  logic          door_enter;
  logic          door_hold;
  logic          frozen;

  logic [FW-1:0] floor_up, floor_dn;
  assign floor_up = current_floor + 1'b1;
  assign floor_dn = current_floor - 1'b1;

`ifdef ELEV_ESTOP_EN
  assign frozen = estop;
`else
  assign frozen = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Call geometry relative to the current floor
  // ---------------------------------------------------------------------------
  logic                  calls_above, calls_below;
  logic [NUM_FLOORS-1:0] near_above, near_below;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    calls_above = 1'b0;
    calls_below = 1'b0;
    near_above  = '0;
    near_below  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i > int'(current_floor))) calls_above = 1'b1;
      if (pending[i] && (i < int'(current_floor))) calls_below = 1'b1;
    end
    // Descending scan: the last hit is the closest call above.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(current_floor))) begin
        near_above    = '0;
        near_above[i] = 1'b1;
      end
    end
    // Ascending scan: the last hit is the closest call below.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i < int'(current_floor))) begin
        near_below    = '0;
        near_below[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduling decision, shared by IDLE and door expiry
  // ---------------------------------------------------------------------------
  state_t dec_state;
  logic   dec_dir;

  always_comb begin
    dec_state = ST_IDLE;
    dec_dir   = dir;
    if (pending[current_floor]) begin
      dec_state = ST_DOOR;
    end else if (dir ? calls_above : calls_below) begin
      dec_state = dir ? ST_UP : ST_DOWN;
    end else if (dir ? calls_below : calls_above) begin
      dec_dir   = ~dir;
      dec_state = dir ? ST_DOWN : ST_UP;
    end
  end

  // A hall call at the open door keeps it open instead of becoming pending.
  // It acts every clk, and overrides an expiry on the same cycle so the
  // caller is never left behind.
  assign door_hold = (state == ST_DOOR) && call_req[current_floor] && !frozen;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    dir_next   = dir;
    floor_next = current_floor;
    move_next  = move_cnt;
    door_next  = door_cnt;
    door_enter = 1'b0;

    if (!frozen) begin
      unique case (state)
        ST_IDLE: begin
          if (tick) begin
            state_next = dec_state;
            dir_next   = dec_dir;
            move_next  = '0;
            door_enter = (dec_state == ST_DOOR);
          end
        end

        ST_UP: begin
          if (tick) begin
            if (move_cnt == MOVE_LAST) begin
              move_next = '0;
              if (current_floor != TOP_FLOOR) begin
                floor_next = floor_up;
                if (pending[floor_up]) begin
                  state_next = ST_DOOR;
                  door_enter = 1'b1;
                end
              end else begin
                // Nothing above the top floor: stop and let IDLE re-decide.
                state_next = ST_IDLE;
              end
            end else begin
              move_next = move_cnt + 1'b1;
            end
          end
        end

        ST_DOWN: begin
          if (tick) begin
            if (move_cnt == MOVE_LAST) begin
              move_next = '0;
              if (current_floor != '0) begin
                floor_next = floor_dn;
                if (pending[floor_dn]) begin
                  state_next = ST_DOOR;
                  door_enter = 1'b1;
                end
              end else begin
                state_next = ST_IDLE;
              end
            end else begin
              move_next = move_cnt + 1'b1;
            end
          end
        end

        ST_DOOR: begin
          if (door_hold) begin
            door_next = DOOR_LAST;
          end else if (tick) begin
            if (door_cnt == '0) begin
              state_next = dec_state;
              dir_next   = dec_dir;
              move_next  = '0;
              door_enter = (dec_state == ST_DOOR);
            end else begin
              door_next = door_cnt - 1'b1;
            end
          end
        end

        default: state_next = ST_IDLE;
      endcase
    end

    if (door_enter) door_next = DOOR_LAST;
  end

  // Call latching. The clear for a floor whose door is opening is applied
  // last, so a simultaneous call for that floor is absorbed by the opening.
  always_comb begin
    pending_next = pending | call_req;
    if (door_hold)  pending_next[current_floor] = pending[current_floor];
    if (door_enter) pending_next[floor_next]    = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state         <= ST_IDLE;
      dir           <= 1'b1;
      current_floor <= '0;
      move_cnt      <= '0;
      door_cnt      <= '0;
      pending       <= '0;
      arrive        <= 1'b0;
    end else begin
      state         <= state_next;
      dir           <= dir_next;
      current_floor <= floor_next;
      move_cnt      <= move_next;
      door_cnt      <= door_next;
      pending       <= pending_next;
      arrive        <= door_enter;
    end
  end

  // ---------------------------------------------------------------------------
  // Display outputs, combinational from registers
  // ---------------------------------------------------------------------------
  assign sim_state = frozen ? 2'b00 : state;

  always_comb begin
    destination = '0;
    unique case (state)
      ST_IDLE: destination = '0;
      ST_DOOR: destination = NUM_FLOORS'(1) << current_floor;
      ST_UP:   destination = near_above;
      ST_DOWN: destination = near_below;
      default: destination = '0;
    endcase
  end

endmodule
